// File: rtl/nlfsr_pkg.sv
// Shared types and helpers for the NLFSR tap sequencer: FSM state encoding,
// tap index width and the reset contents of a coefficient slot.
package nlfsr_pkg;

  localparam int TAP_IDX_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RUN   = 3'd2,
    ST_STALL = 3'd3,
    ST_FLUSH = 3'd4
  } tap_ctrl_state_t;

  // Slot k powers up holding tap index k+1.
  function automatic logic [TAP_IDX_W-1:0] default_slot(input int unsigned k);
    default_slot = TAP_IDX_W'(k + 32'd1);
  endfunction

endpackage

// File: rtl/nlfsr_tap_ctrl_tap_cfg_regfile.sv
// Coefficient table for the tap stage. Writes are accepted only while the
// sequencer is idle and only for in-range slot/tap indices; anything else pulses cfg_err.
module tap_cfg_regfile
  import nlfsr_pkg::*;
#(
  parameter int NUM_OF_TAPS = 15,
  parameter int SIZE        = 32,
  parameter int ADDR_W      = $clog2(NUM_OF_TAPS)
) (
  input  logic                             clk,
  input  logic                             res,
  input  logic                             cfg_open,
  input  logic                             cfg_we,
  input  logic [ADDR_W-1:0]                cfg_addr,
  input  logic [TAP_IDX_W-1:0]             cfg_data,
  output logic [NUM_OF_TAPS*TAP_IDX_W-1:0] co_buf,
  output logic                             cfg_err
);

  logic addr_ok;
  logic data_ok;
  logic accept;
  logic reject;

  // Classify the current write request.
  always_comb begin
    addr_ok = 1'b0;
    data_ok = 1'b0;
    accept  = 1'b0;
    reject  = 1'b0;
    addr_ok = (int'(cfg_addr) < NUM_OF_TAPS);
    data_ok = (int'(cfg_data) < SIZE);
    if (cfg_we) begin
      accept = cfg_open && addr_ok && data_ok;
      reject = !accept;
    end else begin
      accept = 1'b0;
      reject = 1'b0;
    end
  end

  // Table storage and the registered error pulse.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int k = 0; k < NUM_OF_TAPS; k++) begin
        co_buf[k*TAP_IDX_W +: TAP_IDX_W] <= default_slot(k);
      end
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= reject;
      for (int k = 0; k < NUM_OF_TAPS; k++) begin
        if (accept && (cfg_addr == ADDR_W'(k))) begin
          co_buf[k*TAP_IDX_W +: TAP_IDX_W] <= cfg_data;
        end
      end
    end
  end

endmodule

// File: rtl/nlfsr_tap_ctrl.sv
// NLFSR tap-stage sequencer: drives tap_start/nlfsr_step, packs the result bit
// stream MSB-first into words on a valid/ready port. Optional warm-up: NLFSR_TAP_CTRL_WARMUP_EN.
module nlfsr_tap_ctrl
  import nlfsr_pkg::*;
#(
  parameter int NUM_OF_TAPS = 15,
  parameter int SIZE        = 32,
  parameter int OUT_W       = 32,
  parameter int WARMUP      = 64
) (
  input  logic                             clk,
  input  logic                             res,
  input  logic                             cfg_we,
  input  logic [$clog2(NUM_OF_TAPS)-1:0]   cfg_addr,
  input  logic [7:0]                       cfg_data,
  output logic                             cfg_err,
  input  logic                             run_req,
  input  logic                             stop_req,
  input  logic [15:0]                      nwords,
  output logic [NUM_OF_TAPS*TAP_IDX_W-1:0] co_buf,
  output logic                             tap_start,
  output logic                             nlfsr_step,
  input  logic                             xor_result,
  output logic [OUT_W-1:0]                 word_out,
  output logic                             word_valid,
  input  logic                             word_ready,
  output logic                             busy,
  output logic                             done
);

  localparam int ADDR_W = $clog2(NUM_OF_TAPS);
  localparam int BC_W   = $clog2(OUT_W);

  tap_ctrl_state_t state;
  tap_ctrl_state_t next_state;

  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] shifted;
  logic [BC_W-1:0]  bit_cnt;
  logic [15:0]      word_cnt;
  logic [15:0]      nwords_q;
  logic             stop_pend;
  logic             pulse;
  logic             warming;
  logic             capture;
  logic             out_free;
  logic             last_bit;
  logic             last_word;
  logic             load_run;
  logic             load_stall;

  tap_cfg_regfile #(
    .NUM_OF_TAPS (NUM_OF_TAPS),
    .SIZE        (SIZE),
    .ADDR_W      (ADDR_W)
  ) u_cfg (
    .clk      (clk),
    .res      (res),
    .cfg_open (state == ST_IDLE),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .co_buf   (co_buf),
    .cfg_err  (cfg_err)
  );

`ifdef NLFSR_TAP_CTRL_WARMUP_EN
  localparam int WC_W = $clog2(WARMUP + 1);
  logic [WC_W-1:0] warm_cnt;

  assign warming = (warm_cnt != WC_W'(WARMUP));

  // Counts discarded bits after ARM; cleared whenever the sequencer is idle.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      warm_cnt <= '0;
    end else if (state == ST_IDLE) begin
      warm_cnt <= '0;
    end else if ((state == ST_RUN) && warming) begin
      warm_cnt <= warm_cnt + WC_W'(1);
    end else begin
      warm_cnt <= warm_cnt;
    end
  end
`else
  // Warm-up disabled in this build: packing begins with the first bit after ARM.
  assign warming = (WARMUP < 0);
`endif

  assign tap_start  = pulse;
  assign nlfsr_step = pulse;

  // Datapath decode shared by the FSM and the registers.
  always_comb begin
    shifted    = {acc[OUT_W-2:0], xor_result};
    out_free   = !word_valid || word_ready;
    last_bit   = (bit_cnt == BC_W'(OUT_W - 1));
    last_word  = ((nwords_q != 16'd0) && ((word_cnt + 16'd1) == nwords_q))
                 || stop_pend || stop_req;
    capture    = (state == ST_RUN) && !warming;
    load_run   = capture && last_bit && out_free;
    load_stall = (state == ST_STALL) && word_valid && word_ready;
  end

  // Next-state and pulse generation.
  always_comb begin
    next_state = state;
    pulse      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run_req) begin
          next_state = ST_ARM;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_ARM: begin
        pulse      = 1'b1;
        next_state = ST_RUN;
      end
      ST_RUN: begin
        if (warming) begin
          pulse = 1'b1;
          if (stop_pend || stop_req) begin
            next_state = ST_FLUSH;
          end else begin
            next_state = ST_RUN;
          end
        end else if (last_bit && !out_free) begin
          next_state = ST_STALL;
        end else if (last_bit) begin
          pulse      = 1'b1;
          next_state = last_word ? ST_FLUSH : ST_RUN;
        end else begin
          pulse      = 1'b1;
          next_state = ST_RUN;
        end
      end
      ST_STALL: begin
        // The last captured bit had no follow-up sample, so fetch it on release.
        if (load_stall) begin
          pulse      = !last_word;
          next_state = last_word ? ST_FLUSH : ST_RUN;
        end else begin
          next_state = ST_STALL;
        end
      end
      ST_FLUSH: begin
        if (!word_valid) begin
          next_state = ST_IDLE;
        end else begin
          next_state = ST_FLUSH;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // State register plus busy/done status.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != ST_IDLE);
      done  <= (state == ST_FLUSH) && (next_state == ST_IDLE);
    end
  end

  // Run parameters: word target and the sticky stop request.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      nwords_q  <= 16'd0;
      stop_pend <= 1'b0;
    end else if (state == ST_IDLE) begin
      nwords_q  <= run_req ? nwords : nwords_q;
      stop_pend <= 1'b0;
    end else begin
      nwords_q  <= nwords_q;
      stop_pend <= stop_pend || stop_req;
    end
  end

  // Bit accumulator and bit/word counters.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      acc      <= '0;
      bit_cnt  <= '0;
      word_cnt <= 16'd0;
    end else if (state == ST_IDLE) begin
      acc      <= '0;
      bit_cnt  <= '0;
      word_cnt <= 16'd0;
    end else begin
      if (capture) begin
        acc     <= shifted;
        bit_cnt <= last_bit ? '0 : (bit_cnt + BC_W'(1));
      end else begin
        acc     <= acc;
        bit_cnt <= bit_cnt;
      end
      if (load_run || load_stall) begin
        word_cnt <= word_cnt + 16'd1;
      end else begin
        word_cnt <= word_cnt;
      end
    end
  end

  // Output word register with valid/ready handshake.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      word_out   <= '0;
      word_valid <= 1'b0;
    end else if (load_run) begin
      word_out   <= shifted;
      word_valid <= 1'b1;
    end else if (load_stall) begin
      word_out   <= acc;
      word_valid <= 1'b1;
    end else if (word_valid && word_ready) begin
      word_out   <= word_out;
      word_valid <= 1'b0;
    end else begin
      word_out   <= word_out;
      word_valid <= word_valid;
    end
  end

endmodule

// File: tb/tb_nlfsr_tap_ctrl.sv
// Self-checking bench for nlfsr_tap_ctrl with a behavioural tap stage + NLFSR
// and an independent golden bit-stream model.
module tb_nlfsr_tap_ctrl;

  localparam int NT = 15;
  localparam int OW = 32;

  logic           clk = 1'b0;
  logic           res;
  logic           cfg_we;
  logic [3:0]     cfg_addr;
  logic [7:0]     cfg_data;
  logic           cfg_err;
  logic           run_req;
  logic           stop_req;
  logic [15:0]    nwords;
  logic [119:0]   co_buf;
  logic           tap_start;
  logic           nlfsr_step;
  logic           xor_result;
  logic [OW-1:0]  word_out;
  logic           word_valid;
  logic           word_ready;
  logic           busy;
  logic           done;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  logic [31:0]  lfsr;
  logic [31:0]  seed;
  logic         seed_load;
  logic         xor_q;
  logic [119:0] exp_tab;
  logic [119:0] def_tab;
  logic [31:0]  got[$];
  logic [31:0]  golden[$];

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
    logic       err;
    logic [3:0] chk_addr;
    logic [7:0] chk_val;
  } cfg_vec_t;

  cfg_vec_t vec[7];

  always #5 clk = ~clk;

  nlfsr_tap_ctrl dut (
    .clk        (clk),
    .res        (res),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_err    (cfg_err),
    .run_req    (run_req),
    .stop_req   (stop_req),
    .nwords     (nwords),
    .co_buf     (co_buf),
    .tap_start  (tap_start),
    .nlfsr_step (nlfsr_step),
    .xor_result (xor_result),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy),
    .done       (done)
  );

  function automatic logic [31:0] nxt(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0] ^ (s[7] & s[12])};
  endfunction

  function automatic logic tapf(input logic [31:0] s, input logic [119:0] tab);
    logic r;
    r = 1'b0;
    for (int k = 0; k < NT; k++) r = r ^ s[tab[k*8 +: 5]];
    return r;
  endfunction

  // Tap stage + NLFSR model driven by the DUT's pulses and table.
  always @(posedge clk) begin
    if (seed_load) begin
      lfsr  <= seed;
      xor_q <= 1'b0;
    end else begin
      if (tap_start)  xor_q <= tapf(lfsr, co_buf);
      if (nlfsr_step) lfsr  <= nxt(lfsr);
    end
  end
  assign xor_result = xor_q;

  always @(posedge clk) begin
    if (word_valid && word_ready) got.push_back(word_out);
    if (done) done_cnt++;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_run(input logic [31:0] s, input logic [15:0] nw);
    @(negedge clk);
    seed      = s;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    got.delete();
    nwords  = nw;
    run_req = 1'b1;
    @(negedge clk);
    run_req = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int i;
    i = 0;
    while (!done && i < bound) begin
      @(negedge clk);
      i++;
    end
    check(name, 128'(done), 128'(1'b1));
  endtask

  task automatic check_words(input string name, input int n);
    logic [31:0] g;
    logic [31:0] w;
    g = seed;
    w = 32'd0;
    golden.delete();
`ifdef NLFSR_TAP_CTRL_WARMUP_EN
    for (int b = 0; b < 64; b++) g = nxt(g);
`endif
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < OW; b++) begin
        w = {w[30:0], tapf(g, exp_tab)};
        g = nxt(g);
      end
      golden.push_back(w);
    end
    check({name, "_count"}, 128'(got.size()), 128'(n));
    for (int i = 0; i < n && i < got.size(); i++) begin
      check($sformatf("%s_word%0d", name, i), 128'(got[i]), 128'(golden[i]));
    end
  endtask

  initial begin
    int i;
    int d0;
    int stop_words;

    for (int k = 0; k < NT; k++) def_tab[k*8 +: 8] = 8'(k + 1);
    exp_tab = def_tab;

    vec[0] = '{1'b1, 4'd3,  8'd40, 1'b1, 4'd3,  8'd4};
    vec[1] = '{1'b0, 4'd3,  8'd40, 1'b0, 4'd3,  8'd4};
    vec[2] = '{1'b1, 4'd3,  8'd9,  1'b0, 4'd3,  8'd9};
    vec[3] = '{1'b1, 4'd14, 8'd32, 1'b1, 4'd14, 8'd15};
    vec[4] = '{1'b1, 4'd14, 8'd31, 1'b0, 4'd14, 8'd31};
    vec[5] = '{1'b1, 4'd15, 8'd5,  1'b1, 4'd0,  8'd1};
    vec[6] = '{1'b1, 4'd0,  8'd0,  1'b0, 4'd0,  8'd0};

    res = 1'b0; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 8'd0;
    run_req = 1'b0; stop_req = 1'b0; nwords = 16'd0; word_ready = 1'b1;
    seed = 32'h1; seed_load = 1'b1;
    repeat (3) @(negedge clk);
    res = 1'b1;
    seed_load = 1'b0;
    @(negedge clk);
    check("rst_co_buf", 128'(co_buf), 128'(def_tab));
    check("rst_valid", 128'(word_valid), 128'(1'b0));
    check("rst_busy", 128'(busy), 128'(1'b0));
    check("rst_word", 128'(word_out), 128'(32'd0));
    check("rst_tap_start", 128'(tap_start), 128'(1'b0));

    // Configuration vectors
    for (int v = 0; v < 7; v++) begin
      cfg_we = vec[v].we; cfg_addr = vec[v].addr; cfg_data = vec[v].data;
      @(negedge clk);
      cfg_we = 1'b0;
      check($sformatf("cfg%0d_err", v), 128'(cfg_err), 128'(vec[v].err));
      check($sformatf("cfg%0d_slot", v), 128'(co_buf[vec[v].chk_addr*8 +: 8]), 128'(vec[v].chk_val));
      if (vec[v].we && !vec[v].err) exp_tab[vec[v].addr*8 +: 8] = vec[v].data;
    end
    check("cfg_table", 128'(co_buf), 128'(exp_tab));

    // Two words with the consumer always ready
    d0 = done_cnt;
    word_ready = 1'b1;
    start_run(32'hACE1_1234, 16'd2);
    check("arm_tap_start", 128'(tap_start), 128'(1'b1));
    check("arm_busy", 128'(busy), 128'(1'b1));
    wait_done("run2_done", 400);
    repeat (3) @(negedge clk);
    check_words("run2", 2);
    check("run2_done_once", 128'(done_cnt - d0), 128'(1));
    check("run2_idle", 128'(busy), 128'(1'b0));

    // Back-pressure: consumer blocked long enough to force STALL
    word_ready = 1'b0;
    start_run(32'h1357_9BDF, 16'd3);
    i = 0;
    while (!word_valid && i < 300) begin
      @(negedge clk);
      i++;
    end
    check("stall_first_valid", 128'(word_valid), 128'(1'b1));
    repeat (100) @(negedge clk);
    check("stall_tap_start", 128'(tap_start), 128'(1'b0));
    check("stall_step", 128'(nlfsr_step), 128'(1'b0));
    check("stall_busy", 128'(busy), 128'(1'b1));
    word_ready = 1'b1;
    wait_done("stall_done", 400);
    repeat (3) @(negedge clk);
    check_words("stall", 3);

    // Continuous mode, stop after ~10 bits, rejected config write while running
    d0 = done_cnt;
    start_run(32'hDEAD_BEEF, 16'd0);
    repeat (10) @(negedge clk);
    stop_req = 1'b1;
    @(negedge clk);
    stop_req = 1'b0;
    cfg_we = 1'b1; cfg_addr = 4'd2; cfg_data = 8'd5;
    @(negedge clk);
    cfg_we = 1'b0;
    check("run_cfg_err", 128'(cfg_err), 128'(1'b1));
    check("run_cfg_table", 128'(co_buf), 128'(exp_tab));
    wait_done("stop_done", 400);
    repeat (3) @(negedge clk);
`ifdef NLFSR_TAP_CTRL_WARMUP_EN
    stop_words = 0;
`else
    stop_words = 1;
`endif
    check_words("stop", stop_words);
    check("stop_done_once", 128'(done_cnt - d0), 128'(1));

    // Asynchronous reset in the middle of a word
    start_run(32'h0BAD_F00D, 16'd0);
    repeat (20) @(negedge clk);
    d0 = done_cnt;
    #2 res = 1'b0;
    #1;
    check("mid_rst_busy", 128'(busy), 128'(1'b0));
    check("mid_rst_valid", 128'(word_valid), 128'(1'b0));
    check("mid_rst_tap_start", 128'(tap_start), 128'(1'b0));
    check("mid_rst_step", 128'(nlfsr_step), 128'(1'b0));
    check("mid_rst_co_buf", 128'(co_buf), 128'(def_tab));
    @(negedge clk);
    res = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_rst_no_done", 128'(done_cnt - d0), 128'(0));
    check("mid_rst_idle", 128'(busy), 128'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
